// File: rtl/t_flip_seq_ctrl.sv
// t_flip_seq_ctrl
// ---------------------------------------------------------------------------
// Purpose:
//   Sequencer for a bank of WIDTH toggle flip-flops. The bank itself is
//   owned here (q <= q ^ t_vec on every rising edge). The controller only
//   ever changes q through the toggle vector: it loads a start value, counts
//   up or down to a terminal value, then either reloads (auto_reload) or
//   finishes with a one-cycle done pulse.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   start        request a count sequence (only looked at in IDLE)
//   abort        terminate any running sequence, q holds its value
//   mode_up      1 = count up 0..limit, 0 = count down limit..0 (latched)
//   auto_reload  1 = restart at the terminal value instead of finishing
//   limit        terminal (up) or initial (down) value (latched)
//   t_vec        combinational toggle vector applied to the bank this cycle
//   q            current T-flop bank state
//   busy         high whenever the sequencer is not idle
//   done         registered one-cycle pulse, high during the DONE state
//   wrap         registered one-cycle pulse, high the cycle after a reload
// ---------------------------------------------------------------------------
module t_flip_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             mode_up,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Sequence parameters captured when a start is accepted
    logic [WIDTH-1:0] lim_q;
    logic             dir_up_q;
    logic             reload_q;

    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] count_vec;
    logic             at_end;
    logic             latch_en;
    logic             done_nxt;
    logic             wrap_nxt;
    logic             carry;

    // Up counts run 0..lim, down counts run lim..0
    assign init_val = dir_up_q ? '0    : lim_q;
    assign end_val  = dir_up_q ? lim_q : '0;
    assign at_end   = (q == end_val);
    assign busy     = (state != ST_IDLE);

    // Toggle pattern for a +1 / -1 step: bit i flips when every lower bit
    // is 1 (counting up) or 0 (counting down).
    always_comb begin
        count_vec = '0;
        carry     = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            count_vec[i] = carry;
            carry        = carry & (dir_up_q ? q[i] : ~q[i]);
        end
    end

    // Next-state and toggle-vector decode. Abort forces t_vec to zero so the
    // bank keeps its value while the sequencer drops back to idle. Since
    // reset parks the FSM in IDLE, t_vec is already zero while rst is low.
    always_comb begin
        state_nxt = state;
        t_vec     = '0;
        latch_en  = 1'b0;
        done_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    latch_en  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    t_vec     = q ^ init_val;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (!at_end) begin
                    t_vec = count_vec;
                end else if (reload_q) begin
                    t_vec    = q ^ init_val;
                    wrap_nxt = 1'b1;
                end else begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register, pulse outputs and the T-flop bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            q     <= '0;
            done  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q ^ t_vec;
            done  <= done_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Sequence parameters are frozen for the whole run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lim_q    <= '0;
            dir_up_q <= 1'b0;
            reload_q <= 1'b0;
        end else if (latch_en) begin
            lim_q    <= limit;
            dir_up_q <= mode_up;
            reload_q <= auto_reload;
        end
    end

endmodule

// File: tb/tb_t_flip_seq_ctrl.sv
// tb_t_flip_seq_ctrl
// ---------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for t_flip_seq_ctrl. A behavioural model tracks the
//   sequence phase and the bank value with plain arithmetic (q+1 / q-1,
//   direct load of the start value); the expected toggle vector is simply
//   the XOR of the current and next modelled bank values. Directed
//   scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_t_flip_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         mode_up = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] t_vec;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         wrap;

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 load, 2 run, 3 done
    int           m_phase = 0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_t = '0;
    logic [W-1:0] m_lim = '0;
    bit           m_up = 1'b0;
    bit           m_rel = 1'b0;
    bit           m_done = 1'b0;
    bit           m_wrap = 1'b0;

    t_flip_seq_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .mode_up     (mode_up),
        .auto_reload (auto_reload),
        .limit       (limit),
        .t_vec       (t_vec),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    // Compare every DUT output against the model's view of the current cycle
    task automatic checkOutput(input string tag);
        checks++;
        assert (q === m_q) else begin
            failures++;
            $error("[TB] FAIL %s.q observed=%0h expected=%0h", tag, q, m_q);
        end
        checks++;
        assert (t_vec === m_t) else begin
            failures++;
            $error("[TB] FAIL %s.t_vec observed=%0h expected=%0h", tag, t_vec, m_t);
        end
        checks++;
        assert (busy === (m_phase != 0)) else begin
            failures++;
            $error("[TB] FAIL %s.busy observed=%0b expected=%0b", tag, busy, (m_phase != 0));
        end
        checks++;
        assert (done === m_done) else begin
            failures++;
            $error("[TB] FAIL %s.done observed=%0b expected=%0b", tag, done, m_done);
        end
        checks++;
        assert (wrap === m_wrap) else begin
            failures++;
            $error("[TB] FAIL %s.wrap observed=%0b expected=%0b", tag, wrap, m_wrap);
        end
    endtask

    task automatic resetModel();
        m_phase = 0;
        m_q     = '0;
        m_t     = '0;
        m_lim   = '0;
        m_up    = 1'b0;
        m_rel   = 1'b0;
        m_done  = 1'b0;
        m_wrap  = 1'b0;
    endtask

    // Drive one cycle of inputs on the falling edge, check, then advance the
    // model to what the coming rising edge should produce.
    task automatic applyStimulus(input bit s, input bit a, input bit mu,
                                 input bit ar, input logic [W-1:0] lim,
                                 input string tag);
        logic [W-1:0] start_v;
        logic [W-1:0] end_v;
        logic [W-1:0] nq;
        int           nphase;
        bit           ndone;
        bit           nwrap;
        @(negedge clk);
        start       = s;
        abort       = a;
        mode_up     = mu;
        auto_reload = ar;
        limit       = lim;
        start_v = m_up ? '0 : m_lim;
        end_v   = m_up ? m_lim : '0;
        nq      = m_q;
        nphase  = m_phase;
        ndone   = 1'b0;
        nwrap   = 1'b0;
        if (m_phase != 0 && a) begin
            nphase = 0;
        end else begin
            case (m_phase)
                0: if (s && !a) begin
                    m_lim  = lim;
                    m_up   = mu;
                    m_rel  = ar;
                    nphase = 1;
                end
                1: begin
                    nq     = start_v;
                    nphase = 2;
                end
                2: if (m_q == end_v) begin
                    if (m_rel) begin
                        nq    = start_v;
                        nwrap = 1'b1;
                    end else begin
                        nphase = 3;
                        ndone  = 1'b1;
                    end
                end else begin
                    nq = m_up ? m_q + 1'b1 : m_q - 1'b1;
                end
                default: nphase = 0;
            endcase
        end
        m_t = m_q ^ nq;
        #1;
        checkOutput(tag);
        m_q     = nq;
        m_phase = nphase;
        m_done  = ndone;
        m_wrap  = nwrap;
    endtask

    // Idle the inputs until the model is back in IDLE, with a cycle budget
    task automatic runUntilIdle(input string tag, input int budget);
        int n;
        n = 0;
        while (m_phase != 0 && n < budget) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, tag);
            n++;
        end
        checks++;
        if (m_phase != 0) begin
            failures++;
            $display("[TB] FAIL %s.timeout observed=busy expected=idle within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        // Reset state, checked while rst is still low
        repeat (2) @(negedge clk);
        #1;
        resetModel();
        checkOutput("reset");
        rst = 1'b1;

        // Up count 0..5, no reload
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, "up5_start");
        runUntilIdle("up5", 20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "up5_idle");

        // Leave q=9, then count down from 3 (LOAD toggles 4'b1010)
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, "up9_start");
        runUntilIdle("up9", 20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, "down3_start");
        runUntilIdle("down3", 20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "down3_idle");

        // Auto-reload 0,1,2 repeating, ended by abort
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, "reload2_start");
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "reload2_run");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, "reload2_abort");

        // Abort at q=4, then an immediate restart counts from 0
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd10, "abort_start");
        for (int i = 0; i < 20 && !(m_phase == 2 && m_q == 4'd4); i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "abort_run");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, "abort_q4");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, "restart");
        runUntilIdle("restart", 20);

        // Start / limit changes while busy are ignored
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, "busy6_start");
        for (int i = 0; i < 6; i++)
            applyStimulus(i[0], 1'b0, 1'b0, 1'b1, 4'd1, "busy6_noise");
        runUntilIdle("busy6", 20);

        // limit=0 without and with reload
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "zero_start");
        runUntilIdle("zero", 10);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, "zero_rel_start");
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "zero_rel_run");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, "zero_rel_abort");

        // Full-range up count stops at all-ones; abort in IDLE blocks start
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd15, "idle_abort");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd15, "full_start");
        runUntilIdle("full", 30);

        // Asynchronous reset between edges at q=5
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, "areset_start");
        for (int i = 0; i < 20 && !(m_phase == 2 && m_q == 4'd5); i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "areset_run");
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        resetModel();
        checkOutput("areset");
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          W'($urandom_range(0, 15)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
